// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: widths, MEM_ALL bit
// positions, exception bit positions and the per-instruction state encoding.
package mem_stage_pkg;

    localparam int DW        = 32;
    localparam int EXC_W     = 7;
    localparam int MEM_ALL_W = 8;
    localparam int RF_ALL_W  = 6;
    localparam int FWD_W     = 1 + RF_ALL_W + DW;

    localparam int MEM_WE = 7;
    localparam int LD_B   = 6;
    localparam int LD_H   = 5;
    localparam int LD_W   = 4;
    localparam int LD_SE  = 3;
    localparam int ST_B   = 2;
    localparam int ST_H   = 1;
    localparam int ST_W   = 0;

    typedef enum logic [2:0] {
        EXC_INT  = 3'd0,
        EXC_ADEF = 3'd1,
        EXC_ALE  = 3'd2,
        EXC_SYS  = 3'd3,
        EXC_BRK  = 3'd4,
        EXC_INE  = 3'd5,
        EXC_ERTN = 3'd6
    } exc_bit_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } mem_state_e;

    function automatic logic any_exc(input logic [EXC_W-1:0] exc);
        return |exc;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EXE -> MEM handshake and payload bus. EXE drives through master, MEM
// consumes through slave and answers with mem_allowin.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                 exe_to_mem_valid;
    logic                 mem_allowin;
    logic [DW-1:0]        exe_pc;
    logic [DW-1:0]        exe_result;
    logic                 exe_res_from_mem;
    logic [MEM_ALL_W-1:0] exe_mem_all;
    logic [RF_ALL_W-1:0]  exe_rf_all;
    logic                 exe_req_sent;
    logic [EXC_W-1:0]     exe_exc_rf;

    modport master (
        output exe_to_mem_valid, exe_pc, exe_result, exe_res_from_mem,
               exe_mem_all, exe_rf_all, exe_req_sent, exe_exc_rf,
        input  mem_allowin
    );

    modport slave (
        input  exe_to_mem_valid, exe_pc, exe_result, exe_res_from_mem,
               exe_mem_all, exe_rf_all, exe_req_sent, exe_exc_rf,
        output mem_allowin
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Picks the byte/halfword addressed by the low address bits out of a read word
// and sign- or zero-extends it; full words pass through unchanged.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    addr_lo,
    input  logic          ld_b,
    input  logic          ld_h,
    input  logic          ld_se,
    output logic [DW-1:0] load_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection by address offset
    always_comb begin
        case (addr_lo)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (addr_lo[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Width selection and extension
    always_comb begin
        if (ld_b) begin
            load_data = {{(DW-8){ld_se & byte_s[7]}}, byte_s};
        end else if (ld_h) begin
            load_data = {{(DW-16){ld_se & half_s[15]}}, half_s};
        end else begin
            load_data = rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, waits for its data_sram
// response, extracts load data and drops responses orphaned by a flush.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    mem_stage_if.slave          exe_if,
    input  logic                cancel_flush,
    input  logic                data_sram_data_ok,
    input  logic [DW-1:0]       data_sram_rdata,
    input  logic                wb_allowin,
    output logic                mem_to_wb_valid,
    output logic [DW-1:0]       mem_pc,
    output logic [DW-1:0]       mem_final_result,
    output logic [RF_ALL_W-1:0] mem_rf_all,
    output logic [EXC_W-1:0]    mem_exc_rf,
    output logic [FWD_W-1:0]    mem_fwd_all,
    output logic                mem_pipeline_block
);

    mem_state_e           state_d, state_q;
    logic                 mem_valid_d, mem_valid_q;
    logic [DW-1:0]        pc_d, pc_q;
    logic [DW-1:0]        result_d, result_q;
    logic                 res_from_mem_d, res_from_mem_q;
    logic [MEM_ALL_W-1:0] mem_all_d, mem_all_q;
    logic [RF_ALL_W-1:0]  rf_all_d, rf_all_q;
    logic [EXC_W-1:0]     exc_d, exc_q;
    logic [DW-1:0]        rbuf_d, rbuf_q;
    logic [1:0]           discard_cnt_d, discard_cnt_q;

    logic                 data_ok_s;
    logic                 ready_go_s;
    logic                 allowin_s;
    logic                 capture_s;
    logic [1:0]           discard_inc_s;
    logic                 discard_dec_s;
    logic [DW-1:0]        load_src_s;
    logic [DW-1:0]        load_data_s;
    logic [DW-1:0]        final_s;
    logic                 blocking_s;
    logic                 unused_mem_all_s;

    // Handshake: a response only counts once every orphaned response has drained
    always_comb begin
        data_ok_s  = data_sram_data_ok & (discard_cnt_q == 2'd0);
        ready_go_s = (state_q == S_DONE)
                   | ((state_q == S_WAIT) & data_ok_s)
                   | any_exc(exc_q);
        allowin_s  = ~mem_valid_q | (ready_go_s & wb_allowin);
        capture_s  = exe_if.exe_to_mem_valid & allowin_s;
    end

    assign exe_if.mem_allowin = allowin_s;

    // Next-state for valid bit, FSM, payload, response buffer and discard count
    always_comb begin
        mem_valid_d    = mem_valid_q;
        state_d        = state_q;
        pc_d           = pc_q;
        result_d       = result_q;
        res_from_mem_d = res_from_mem_q;
        mem_all_d      = mem_all_q;
        rf_all_d       = rf_all_q;
        exc_d          = exc_q;
        rbuf_d         = rbuf_q;

        if (cancel_flush) begin
            mem_valid_d = 1'b0;
            state_d     = S_IDLE;
        end else if (allowin_s) begin
            mem_valid_d = exe_if.exe_to_mem_valid;
            if (!exe_if.exe_to_mem_valid) begin
                state_d = S_IDLE;
            end else if (exe_if.exe_req_sent) begin
                state_d = S_WAIT;
            end else begin
                state_d = S_DONE;
            end
        end else if ((state_q == S_WAIT) && data_ok_s) begin
            state_d = S_DONE;
        end else begin
            state_d = state_q;
        end

        if (capture_s) begin
            pc_d           = exe_if.exe_pc;
            result_d       = exe_if.exe_result;
            res_from_mem_d = exe_if.exe_res_from_mem;
            mem_all_d      = exe_if.exe_mem_all;
            rf_all_d       = exe_if.exe_rf_all;
            exc_d          = exe_if.exe_exc_rf;
        end else begin
            pc_d = pc_q;
        end

        if ((state_q == S_WAIT) && data_ok_s) begin
            rbuf_d = data_sram_rdata;
        end else begin
            rbuf_d = rbuf_q;
        end

        // A flushed request that already got addr_ok still owes a response
        discard_inc_s = {1'b0, cancel_flush & (state_q == S_WAIT) & ~data_ok_s}
                      + {1'b0, cancel_flush & capture_s & exe_if.exe_req_sent};
        discard_dec_s = data_sram_data_ok & (discard_cnt_q != 2'd0);
        discard_cnt_d = discard_cnt_q + discard_inc_s - {1'b0, discard_dec_s};
    end

    // Data source: buffered word once the response has been parked
    always_comb begin
        if (state_q == S_DONE) begin
            load_src_s = rbuf_q;
        end else begin
            load_src_s = data_sram_rdata;
        end
    end

    mem_load_align u_load_align (
        .rdata     (load_src_s),
        .addr_lo   (result_q[1:0]),
        .ld_b      (mem_all_q[LD_B]),
        .ld_h      (mem_all_q[LD_H]),
        .ld_se     (mem_all_q[LD_SE]),
        .load_data (load_data_s)
    );

    // Result, forwarding and WB handshake outputs
    always_comb begin
        if (res_from_mem_q) begin
            final_s = load_data_s;
        end else begin
            final_s = result_q;
        end
        blocking_s         = mem_valid_q & res_from_mem_q & ~ready_go_s;
        mem_to_wb_valid    = mem_valid_q & ready_go_s & ~cancel_flush;
        mem_pipeline_block = mem_valid_q & any_exc(exc_q);
        if (mem_valid_q) begin
            mem_fwd_all = {blocking_s, rf_all_q, final_s};
        end else begin
            mem_fwd_all = {FWD_W{1'b0}};
        end
    end

    assign mem_pc           = pc_q;
    assign mem_final_result = final_s;
    assign mem_rf_all       = rf_all_q;
    assign mem_exc_rf       = exc_q;

    assign unused_mem_all_s = ^{mem_all_q[MEM_WE], mem_all_q[LD_W],
                                mem_all_q[ST_B], mem_all_q[ST_H], mem_all_q[ST_W]};

    // Stage registers and per-instruction FSM state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_q    <= 1'b0;
            state_q        <= S_IDLE;
            pc_q           <= {DW{1'b0}};
            result_q       <= {DW{1'b0}};
            res_from_mem_q <= 1'b0;
            mem_all_q      <= {MEM_ALL_W{1'b0}};
            rf_all_q       <= {RF_ALL_W{1'b0}};
            exc_q          <= {EXC_W{1'b0}};
            rbuf_q         <= {DW{1'b0}};
            discard_cnt_q  <= 2'd0;
        end else begin
            mem_valid_q    <= mem_valid_d;
            state_q        <= state_d;
            pc_q           <= pc_d;
            result_q       <= result_d;
            res_from_mem_q <= res_from_mem_d;
            mem_all_q      <= mem_all_d;
            rf_all_q       <= rf_all_d;
            exc_q          <= exc_d;
            rbuf_q         <= rbuf_d;
            discard_cnt_q  <= discard_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: inputs change on the falling edge, outputs are
// checked 1ns later against hand-computed values.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam logic [7:0] M_LD_W  = 8'h10;
    localparam logic [7:0] M_LD_B  = 8'h40;
    localparam logic [7:0] M_LD_BS = 8'h48;
    localparam logic [7:0] M_LD_H  = 8'h20;
    localparam logic [7:0] M_LD_HS = 8'h28;
    localparam logic [7:0] M_ST_W  = 8'h81;

    logic        clk;
    logic        resetn;
    logic        cancel_flush;
    logic        data_ok;
    logic [31:0] rdata;
    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_final_result;
    logic [5:0]  mem_rf_all;
    logic [6:0]  mem_exc_rf;
    logic [38:0] mem_fwd_all;
    logic        mem_pipeline_block;

    int checks = 0;
    int errors = 0;

    mem_stage_if exe_bus ();

    mem_stage dut (
        .clk                (clk),
        .resetn             (resetn),
        .exe_if             (exe_bus),
        .cancel_flush       (cancel_flush),
        .data_sram_data_ok  (data_ok),
        .data_sram_rdata    (rdata),
        .wb_allowin         (wb_allowin),
        .mem_to_wb_valid    (mem_to_wb_valid),
        .mem_pc             (mem_pc),
        .mem_final_result   (mem_final_result),
        .mem_rf_all         (mem_rf_all),
        .mem_exc_rf         (mem_exc_rf),
        .mem_fwd_all        (mem_fwd_all),
        .mem_pipeline_block (mem_pipeline_block)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_exe(input logic v, input logic [31:0] pc, input logic [31:0] addr,
                             input logic ld, input logic [7:0] ma, input logic [5:0] rf,
                             input logic req, input logic [6:0] exc);
        exe_bus.exe_to_mem_valid = v;
        exe_bus.exe_pc           = pc;
        exe_bus.exe_result       = addr;
        exe_bus.exe_res_from_mem = ld;
        exe_bus.exe_mem_all      = ma;
        exe_bus.exe_rf_all       = rf;
        exe_bus.exe_req_sent     = req;
        exe_bus.exe_exc_rf       = exc;
    endtask

    task automatic idle_exe();
        drive_exe(1'b0, 32'h0, 32'h0, 1'b0, 8'h00, 6'h00, 1'b0, 7'h00);
    endtask

    // Load whose response arrives the cycle after capture
    task automatic load_next(input string tag, input logic [31:0] addr, input logic [7:0] ma,
                             input logic [31:0] rd, input logic [31:0] exp);
        @(negedge clk);
        drive_exe(1'b1, 32'h1c00_0100, addr, 1'b1, ma, 6'h25, 1'b1, 7'h00);
        #1 chk({tag, "_allowin"}, exe_bus.mem_allowin, 1'b1);
        @(negedge clk);
        idle_exe();
        data_ok = 1'b1;
        rdata   = rd;
        #1;
        chk(tag, mem_final_result, exp);
        chk({tag, "_wbv"}, mem_to_wb_valid, 1'b1);
        @(negedge clk);
        data_ok = 1'b0;
        rdata   = 32'h0;
        #1 chk({tag, "_wbv_off"}, mem_to_wb_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn       = 1'b0;
        cancel_flush = 1'b0;
        data_ok      = 1'b0;
        rdata        = 32'h0;
        wb_allowin   = 1'b1;
        idle_exe();
        #2;
        chk("rst_allowin", exe_bus.mem_allowin, 1'b1);
        chk("rst_wbv", mem_to_wb_valid, 1'b0);
        chk("rst_pc", mem_pc, 32'h0);
        chk("rst_result", mem_final_result, 32'h0);
        chk("rst_fwd", mem_fwd_all, 39'h0);
        chk("rst_block", mem_pipeline_block, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        // 1: ld.w, response three cycles after the request
        @(negedge clk);
        drive_exe(1'b1, 32'h1c00_0000, 32'h0000_1000, 1'b1, M_LD_W, 6'h24, 1'b1, 7'h00);
        #1 chk("t1_allowin_in", exe_bus.mem_allowin, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_exe();
            #1;
            chk("t1_allowin_wait", exe_bus.mem_allowin, 1'b0);
            chk("t1_blocking", mem_fwd_all[38], 1'b1);
            chk("t1_wbv_wait", mem_to_wb_valid, 1'b0);
        end
        chk("t1_pc", mem_pc, 32'h1c00_0000);
        chk("t1_rf", mem_rf_all, 6'h24);
        @(negedge clk);
        data_ok = 1'b1;
        rdata   = 32'hDEAD_BEEF;
        #1;
        chk("t1_wbv", mem_to_wb_valid, 1'b1);
        chk("t1_data", mem_final_result, 32'hDEAD_BEEF);
        chk("t1_fwd", mem_fwd_all, {1'b0, 6'h24, 32'hDEAD_BEEF});
        chk("t1_allowin_go", exe_bus.mem_allowin, 1'b1);
        @(negedge clk);
        data_ok = 1'b0;
        rdata   = 32'h0;
        #1;
        chk("t1_wbv_off", mem_to_wb_valid, 1'b0);
        chk("t1_fwd_off", mem_fwd_all, 39'h0);

        // 2: sub-word extraction
        load_next("t2_ldb_se_3", 32'h0000_1003, M_LD_BS, 32'h80FF_1234, 32'hFFFF_FF80);
        load_next("t2_ldhu_2",   32'h0000_1002, M_LD_H,  32'h80FF_1234, 32'h0000_80FF);
        load_next("t2_ldh_se_2", 32'h0000_1002, M_LD_HS, 32'h80FF_1234, 32'hFFFF_80FF);
        load_next("t2_ldbu_1",   32'h0000_1001, M_LD_B,  32'h80FF_1234, 32'h0000_0012);
        load_next("t2_ldh_se_0", 32'h0000_1000, M_LD_HS, 32'h80FF_1234, 32'h0000_1234);

        // 3: response parked while WB stalls
        @(negedge clk);
        wb_allowin = 1'b0;
        drive_exe(1'b1, 32'h1c00_0010, 32'h0000_1004, 1'b1, M_LD_W, 6'h26, 1'b1, 7'h00);
        @(negedge clk);
        idle_exe();
        data_ok = 1'b1;
        rdata   = 32'hCAFE_F00D;
        #1;
        chk("t3_wbv_ok", mem_to_wb_valid, 1'b1);
        chk("t3_allowin_ok", exe_bus.mem_allowin, 1'b0);
        @(negedge clk);
        data_ok = 1'b0;
        rdata   = 32'h1234_5678;
        #1;
        chk("t3_buf1", mem_final_result, 32'hCAFE_F00D);
        chk("t3_allowin1", exe_bus.mem_allowin, 1'b0);
        @(negedge clk);
        wb_allowin = 1'b1;
        #1;
        chk("t3_buf2", mem_final_result, 32'hCAFE_F00D);
        chk("t3_wbv2", mem_to_wb_valid, 1'b1);
        chk("t3_allowin2", exe_bus.mem_allowin, 1'b1);
        @(negedge clk);
        rdata = 32'h0;
        #1 chk("t3_wbv_off", mem_to_wb_valid, 1'b0);

        // 4: flush in WAIT, orphaned response must be dropped
        @(negedge clk);
        drive_exe(1'b1, 32'h1c00_0020, 32'h0000_1008, 1'b1, M_LD_W, 6'h27, 1'b1, 7'h00);
        @(negedge clk);
        idle_exe();
        cancel_flush = 1'b1;
        #1 chk("t4_wbv_cancel", mem_to_wb_valid, 1'b0);
        @(negedge clk);
        cancel_flush = 1'b0;
        drive_exe(1'b1, 32'h1c00_0024, 32'h0000_2000, 1'b1, M_LD_W, 6'h28, 1'b1, 7'h00);
        #1 chk("t4_allowin_new", exe_bus.mem_allowin, 1'b1);
        @(negedge clk);
        idle_exe();
        data_ok = 1'b1;
        rdata   = 32'h1111_1111;
        #1;
        chk("t4_stale_wbv", mem_to_wb_valid, 1'b0);
        chk("t4_stale_block", mem_fwd_all[38], 1'b1);
        @(negedge clk);
        rdata = 32'h2222_2222;
        #1;
        chk("t4_wbv", mem_to_wb_valid, 1'b1);
        chk("t4_data", mem_final_result, 32'h2222_2222);
        @(negedge clk);
        data_ok = 1'b0;
        rdata   = 32'h0;

        // 4b: response coinciding with the flush is consumed, not counted
        @(negedge clk);
        drive_exe(1'b1, 32'h1c00_0030, 32'h0000_1010, 1'b1, M_LD_W, 6'h29, 1'b1, 7'h00);
        @(negedge clk);
        idle_exe();
        cancel_flush = 1'b1;
        data_ok      = 1'b1;
        rdata        = 32'h3333_3333;
        #1 chk("t4b_wbv_cancel", mem_to_wb_valid, 1'b0);
        @(negedge clk);
        cancel_flush = 1'b0;
        data_ok      = 1'b0;
        drive_exe(1'b1, 32'h1c00_0034, 32'h0000_1014, 1'b1, M_LD_W, 6'h29, 1'b1, 7'h00);
        @(negedge clk);
        idle_exe();
        data_ok = 1'b1;
        rdata   = 32'h4444_4444;
        #1;
        chk("t4b_wbv", mem_to_wb_valid, 1'b1);
        chk("t4b_data", mem_final_result, 32'h4444_4444);
        @(negedge clk);
        data_ok = 1'b0;
        rdata   = 32'h0;

        // 4c: store waits for its write response, no blocking
        @(negedge clk);
        drive_exe(1'b1, 32'h1c00_0040, 32'h0000_3000, 1'b0, M_ST_W, 6'h00, 1'b1, 7'h00);
        @(negedge clk);
        idle_exe();
        #1;
        chk("t4c_allowin", exe_bus.mem_allowin, 1'b0);
        chk("t4c_fwd", mem_fwd_all, {1'b0, 6'h00, 32'h0000_3000});
        @(negedge clk);
        data_ok = 1'b1;
        #1 chk("t4c_wbv", mem_to_wb_valid, 1'b1);
        @(negedge clk);
        data_ok = 1'b0;

        // 5: ALE load is ready at once and blocks EXE
        @(negedge clk);
        drive_exe(1'b1, 32'h1c00_0050, 32'h0000_1001, 1'b1, M_LD_W, 6'h2A, 1'b0, 7'h04);
        @(negedge clk);
        idle_exe();
        #1;
        chk("t5_block", mem_pipeline_block, 1'b1);
        chk("t5_wbv", mem_to_wb_valid, 1'b1);
        chk("t5_exc", mem_exc_rf, 7'h04);
        chk("t5_allowin", exe_bus.mem_allowin, 1'b1);
        @(negedge clk);
        #1;
        chk("t5_block_off", mem_pipeline_block, 1'b0);
        chk("t5_wbv_off", mem_to_wb_valid, 1'b0);

        // 6: asynchronous reset in the middle of WAIT
        @(negedge clk);
        drive_exe(1'b1, 32'h1c00_0060, 32'h0000_1020, 1'b1, M_LD_W, 6'h2B, 1'b1, 7'h00);
        @(negedge clk);
        idle_exe();
        #1 chk("t6_allowin_wait", exe_bus.mem_allowin, 1'b0);
        #1 resetn = 1'b0;
        #1;
        chk("t6_allowin", exe_bus.mem_allowin, 1'b1);
        chk("t6_wbv", mem_to_wb_valid, 1'b0);
        chk("t6_pc", mem_pc, 32'h0);
        chk("t6_result", mem_final_result, 32'h0);
        chk("t6_rf", mem_rf_all, 6'h00);
        chk("t6_exc", mem_exc_rf, 7'h00);
        chk("t6_fwd", mem_fwd_all, 39'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        data_ok = 1'b1;
        rdata   = 32'h5555_5555;
        #1;
        chk("t6_stray_wbv", mem_to_wb_valid, 1'b0);
        chk("t6_stray_allowin", exe_bus.mem_allowin, 1'b1);
        chk("t6_stray_fwd", mem_fwd_all, 39'h0);
        @(negedge clk);
        data_ok = 1'b0;
        rdata   = 32'h0;
        load_next("t6_after", 32'h0000_1000, M_LD_W, 32'h0BAD_F00D, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
